// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
// Holds FSM states, funct3 size codes and the 32-bit bus view.
package load_store_unit_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef union packed {
        logic [31:0]      w;
        logic [1:0][15:0] h;
        logic [3:0][7:0]  b;
    } dataBus_u;

    // Unsigned sizes only exist for loads.
    function automatic logic f3_illegal(
        input logic [2:0] f3,
        input logic       we
    );
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (f3[2] && we);
    endfunction

    function automatic logic f3_misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic half;
        half = (f3 == LSU_H) || (f3 == LSU_HU);
        return (half && off[0]) || ((f3 == LSU_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: enables, store placement, load extraction.
// Purely combinational; one instance serves both directions.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [1:0] off_i,
    input  dataBus_u   wdata_i,
    input  dataBus_u   rdata_i,
    output logic [3:0] be_o,
    output dataBus_u   wdata_o,
    output dataBus_u   rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        byte_v  = rdata_i.b[off_i];
        half_v  = rdata_i.h[off_i[1]];
        unique case (funct3_i)
            LSU_B: begin
                be_o      = 4'b0001 << off_i;
                wdata_o.w = {4{wdata_i.b[0]}};
                rdata_o.w = {{24{byte_v[7]}}, byte_v};
            end
            LSU_BU: begin
                be_o      = 4'b0001 << off_i;
                wdata_o.w = {4{wdata_i.b[0]}};
                rdata_o.w = {24'h0, byte_v};
            end
            LSU_H: begin
                be_o      = 4'b0011 << {off_i[1], 1'b0};
                wdata_o.w = {2{wdata_i.h[0]}};
                rdata_o.w = {{16{half_v[15]}}, half_v};
            end
            LSU_HU: begin
                be_o      = 4'b0011 << {off_i[1], 1'b0};
                wdata_o.w = {2{wdata_i.h[0]}};
                rdata_o.w = {16'h0, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding access, ready handshake,
// alignment and funct3 checks, bounded wait with bus error on timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    dataBus_u      wdata_q;
    logic          rd_q;
    logic          wr_q;
    logic          rsp_valid_q;
    dataBus_u      rsp_rdata_q;
    logic          mis_q;
    logic          berr_q;

    logic [2:0]    al_f3;
    logic [1:0]    al_off;
    logic [3:0]    al_be;
    dataBus_u      al_wdata;
    dataBus_u      al_rdata;

    // Request fields steer lanes at acceptance, latched ones at completion.
    assign al_f3  = (state_q == ACCESS) ? f3_q  : req_funct3;
    assign al_off = (state_q == ACCESS) ? off_q : req_addr[1:0];

    lsu_align u_align (
        .funct3_i (al_f3),
        .off_i    (al_off),
        .wdata_i  (dataBus_u'(req_wdata)),
        .rdata_i  (dataBus_u'(mem_rdata)),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
        end else if (clk_en) begin
            rsp_valid_q <= 1'b0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (f3_illegal(req_funct3, req_we)) begin
                            berr_q <= 1'b1;
                        end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
                            mis_q <= 1'b1;
                        end else begin
                            state_q <= ACCESS;
                            cnt_q   <= '0;
                            we_q    <= req_we;
                            f3_q    <= req_funct3;
                            off_q   <= req_addr[1:0];
                            addr_q  <= {req_addr[31:2], 2'b00};
                            be_q    <= al_be;
                            wdata_q <= al_wdata;
                            rd_q    <= !req_we;
                            wr_q    <= req_we;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        state_q     <= IDLE;
                        rd_q        <= 1'b0;
                        wr_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? '0 : al_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        berr_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q == ACCESS);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q.w;
    assign misaligned = mis_q;
    assign bus_err    = berr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q.w;
    assign mem_be     = be_q;
    assign mem_rd_en  = rd_q;
    assign mem_wr_en  = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed corner cases plus random
// transactions scored against a transaction-level model.
module tb_load_store_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misaligned;
    logic        bus_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
    endtask

    // rdy_at: ACCESS cycle (1-based) that sees mem_ready; 0 = never.
    task automatic run_txn(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int rdy_at);
        logic        ill, mis, sgn;
        int          off, sz;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd, v;
        off = int'(addr[1:0]);
        ill = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4);
        sz  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        sgn = (f3 < 4);
        mis = !ill && (off % sz != 0);
        ebe = '0;
        for (int i = 0; i < sz; i++) ebe |= 4'(1 << (off + i));
        if (sz == 1)      ewd = {24'h0, wd[7:0]} * 32'h0101_0101;
        else if (sz == 2) ewd = {16'h0, wd[15:0]} * 32'h0001_0001;
        else              ewd = wd;
        v = rd >> (8 * off);
        if (sz == 1) begin
            v &= 32'hFF;
            if (sgn && v[7]) v |= 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v &= 32'hFFFF;
            if (sgn && v[15]) v |= 32'hFFFF_0000;
        end
        erd = we ? 32'h0 : v;

        drive_req(we, f3, addr, wd);
        tick();
        req_valid = 1'b0;
        if (ill || mis) begin
            chk("err_bus", bus_err, ill);
            chk("err_mis", misaligned, mis);
            chk("err_busy", busy, 1'b0);
            chk("err_strb", {mem_rd_en, mem_wr_en}, 2'b00);
            chk("err_rsp", rsp_valid, 1'b0);
            tick();
            chk("err_pulse", {bus_err, misaligned}, 2'b00);
            return;
        end
        chk("acc_busy", busy, 1'b1);
        chk("acc_addr", mem_addr, {addr[31:2], 2'b00});
        chk("acc_be", mem_be, ebe);
        chk("acc_strb", {mem_rd_en, mem_wr_en}, {!we, we});
        if (we) chk("acc_wdata", mem_wdata, ewd);
        mem_rdata = rd;
        for (int k = 1; k <= TO; k++) begin
            mem_ready  = (k == rdy_at);
            req_valid  = 1'($urandom);
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            tick();
            req_valid = 1'b0;
            if (k == rdy_at) begin
                mem_ready = 1'b0;
                chk("done_rsp", rsp_valid, 1'b1);
                chk("done_data", rsp_rdata, erd);
                chk("done_err", {bus_err, misaligned}, 2'b00);
                chk("done_idle", {busy, mem_rd_en, mem_wr_en}, 3'b000);
                tick();
                chk("done_pulse", rsp_valid, 1'b0);
                chk("done_stay", busy, 1'b0);
                return;
            end else if (k == TO) begin
                chk("to_err", bus_err, 1'b1);
                chk("to_rsp", rsp_valid, 1'b0);
                chk("to_idle", {busy, mem_rd_en, mem_wr_en}, 3'b000);
                tick();
                chk("to_pulse", bus_err, 1'b0);
                return;
            end else begin
                chk("wait_busy", busy, 1'b1);
                chk("wait_out", {rsp_valid, bus_err}, 2'b00);
                chk("wait_addr", mem_addr, {addr[31:2], 2'b00});
                chk("wait_be", mem_be, ebe);
                chk("wait_strb", {mem_rd_en, mem_wr_en}, {!we, we});
            end
        end
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_outs", {rsp_valid, misaligned, bus_err, mem_rd_en, mem_wr_en}, 5'b0);
        chk("rst_addr", mem_addr, 32'h0);
        #5 rst_n = 1'b1;

        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1);
        run_txn(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 3);
        run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
        run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1);
        run_txn(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1);
        run_txn(1'b0, 3'b101, 32'h10, 32'h0, 32'hBEEF_8001, 0);
        run_txn(1'b0, 3'b101, 32'h10, 32'h0, 32'hBEEF_8001, TO);

        // Asynchronous reset in the middle of a read.
        drive_req(1'b0, 3'b010, 32'h80, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("mid_busy", busy, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rd", mem_rd_en, 1'b0);
        chk("arst_busy", busy, 1'b0);
        tick();
        chk("arst_rsp", rsp_valid, 1'b0);
        #2 rst_n = 1'b1;
        run_txn(1'b0, 3'b100, 32'h1, 32'h0, 32'h0000_9A00, 1);

        // Clock enable freezes a completing access, then stretches the pulse.
        drive_req(1'b0, 3'b010, 32'h44, 32'h0);
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h1122_3344;
        clk_en    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ce_hold", {busy, mem_rd_en, rsp_valid}, 3'b110);
        end
        clk_en = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("ce_rsp", rsp_valid, 1'b1);
        chk("ce_data", rsp_rdata, 32'h1122_3344);
        clk_en = 1'b0;
        tick();
        chk("ce_stretch", rsp_valid, 1'b1);
        clk_en = 1'b1;
        tick();
        chk("ce_clear", rsp_valid, 1'b0);

        for (int n = 0; n < 200; n++) begin
            int ra;
            ra = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
            if ($urandom_range(0, 3) == 0) begin
                mem_ready = 1'($urandom);
                tick();
                mem_ready = 1'b0;
                chk("idle_busy", {busy, rsp_valid}, 2'b00);
            end
            run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
